// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
// It merges the per-stage stall requests into one stall vector. It turns a MEM-stage
// exception or mret into a single-cycle flush with a redirect PC, and holds that flush
// back while a data-bus transaction is still outstanding.
// Optional build macro: PIPE_CTRL_WDOG_EN adds a stall watchdog with a sticky
// wdog_timeout flag. Without it, wdog_timeout is tied to 0.
module pipe_ctrl #(
  parameter int WDOG_LIMIT = 1023,
  parameter int WDOG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_is_ret,
  input  logic        bus_busy,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        wdog_timeout
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    TRAP_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  req_stall;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic        capture_pc;
  logic [31:0] trap_target;

  // The deepest requesting stage wins, because it freezes itself and everything behind it.
  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem)     req_stall = 6'b011111;
    else if (stallreq_ex) req_stall = 6'b001111;
    else if (stallreq_id) req_stall = 6'b000111;
    else if (stallreq_if) req_stall = 6'b000011;
  end

  // An mret returns to mepc. Traps go to mtvec with the mode bits forced to direct.
  assign trap_target = except_is_ret ? csr_mepc : (csr_mtvec & 32'hFFFF_FFFC);

  // Next-state and output decode. The whole pipe is frozen while a trap waits on the
  // bus, and on the accept cycle, so the excepting instruction stays parked in MEM.
  always_comb begin
    state_nxt  = state;
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    capture_pc = 1'b0;
    case (state)
      RUN: begin
        if (except_valid) begin
          stall_c = 6'b111111;
          if (bus_busy) begin
            state_nxt = TRAP_WAIT;
          end else begin
            capture_pc = 1'b1;
            state_nxt  = FLUSH;
          end
        end else begin
          stall_c = req_stall;
        end
      end
      TRAP_WAIT: begin
        if (!except_valid) begin
          stall_c   = req_stall;
          state_nxt = RUN;
        end else begin
          stall_c = 6'b111111;
          if (!bus_busy) begin
            capture_pc = 1'b1;
            state_nxt  = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_c   = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Gate the combinational outputs with reset, so that stall requests arriving during
  // reset never reach the pipeline registers.
  assign stall = rst ? stall_c : 6'b000000;
  assign flush = rst & flush_c;

  // State register. An asynchronous reset abandons any pending trap without a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Redirect target is captured on the accept cycle and held until the next trap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            new_pc <= 32'h0000_0000;
    else if (capture_pc) new_pc <= trap_target;
  end

  // Saturating count of cycles in which the PC was frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0000_0000;
    end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WdogMax = WDOG_W'(WDOG_LIMIT);

  logic              any_req;
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W-1:0] wdog_nxt;

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Count consecutive request-driven stall cycles in RUN. The count saturates at the limit.
  always_comb begin
    wdog_nxt = '0;
    if ((state == RUN) && any_req) begin
      wdog_nxt = (wdog_cnt == WdogMax) ? wdog_cnt : wdog_cnt + WDOG_W'(1);
    end
  end

  // Watchdog counter and sticky timeout flag. Only reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt     <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nxt;
      if (wdog_nxt == WdogMax) wdog_timeout <= 1'b1;
    end
  end
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 6-stage RISC-V core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the stall[5:0] vector consumed by every pipeline register, including ex_mem. It also turns a MEM-stage exception or mret into a one-cycle flush pulse with a redirect PC. A small FSM keeps the flush from landing while a bus transaction is outstanding.

Parameters:
WDOG_LIMIT, 1023, consecutive request-driven stall cycles before the watchdog fires (used only with PIPE_CTRL_WDOG_EN).
WDOG_W, 10, width of the watchdog counter; must satisfy 2^WDOG_W > WDOG_LIMIT.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset (0 = reset)
stallreq_if  in  1  IF stall request (instruction bus wait)
stallreq_id  in  1  ID stall request (load-use)
stallreq_ex  in  1  EX stall request (multi-cycle op)
stallreq_mem  in  1  MEM stall request (data bus wait)
except_valid  in  1  MEM-stage instruction has a nonzero excepttype
except_is_ret  in  1  that exception is an mret
bus_busy  in  1  a data-bus transaction is outstanding
csr_mtvec  in  32  trap vector
csr_mepc  in  32  return address
stall  out  6  bit i freezes stage i; bit 0 = PC
flush  out  1  clear all pipeline registers
new_pc  out  32  redirect target, valid while flush=1
stall_cycles  out  32  saturating count of cycles with stall[0]=1
wdog_timeout  out  1  sticky watchdog flag (constant 0 without PIPE_CTRL_WDOG_EN)

Behaviour:
- FSM states: RUN, TRAP_WAIT, FLUSH. All state is async-reset to RUN.
- Reset values (rst=0): stall=6'b000000, flush=0, new_pc=0, stall_cycles=0, wdog_timeout=0.
- RUN, except_valid=0:
  - stall is combinational from requests. Priority is mem > ex > id > if.
  - mem → 6'b011111; ex → 6'b001111; id → 6'b000111; if → 6'b000011; none → 6'b000000.
  - flush=0.
- RUN, except_valid=1, bus_busy=1:
  - stall=6'b111111.
  - Next state TRAP_WAIT.
- RUN or TRAP_WAIT, except_valid=1, bus_busy=0:
  - stall=6'b111111 for this cycle, so the excepting instruction is held in MEM.
  - Register new_pc <= except_is_ret ? csr_mepc : {csr_mtvec[31:2],2'b00}.
  - Next state FLUSH.
- TRAP_WAIT, bus_busy=1: stall=6'b111111, remain in TRAP_WAIT.
- TRAP_WAIT, except_valid dropped: return to RUN with no flush. This is a defensive case.
- FLUSH:
  - flush=1 and stall=6'b000000 for exactly one cycle. new_pc holds its registered value.
  - Stall requests and except_valid are ignored this cycle, because the flush clears their sources.
  - Next state RUN.
- Exception latency: from except_valid sampled with the bus idle to flush=1 is 1 cycle.
- Back-to-back exceptions: the cycle after FLUSH is in RUN, so a new except_valid is accepted normally.
- new_pc keeps its last value outside FLUSH.
- stall_cycles:
  - Increments on every clock edge where stall[0]=1, in any state.
  - Saturates at 32'hFFFFFFFF and does not wrap.
- Reset asserted mid-trap (TRAP_WAIT or FLUSH): outputs go to reset values immediately (asynchronous), with no partial flush.

Optional Feature:
Macro PIPE_CTRL_WDOG_EN.
- Defined:
  - A WDOG_W-bit counter increments each cycle in RUN where any stallreq_* is 1.
  - It clears on any cycle with no request, and in TRAP_WAIT/FLUSH.
  - When the counter reaches WDOG_LIMIT, wdog_timeout is set to 1 and stays 1 until rst.
  - The counter holds at WDOG_LIMIT.
  - The pipeline behaviour is unchanged.
- Not defined: no counter logic; wdog_timeout is tied to 0.

Test Plan:
- Reset, then set stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111 in the same cycle; stall_cycles increments by 1 per cycle.
- All four stallreq_* =1 → stall=6'b011111. Drop stallreq_mem only → stall=6'b001111 next cycle.
- except_valid=1, except_is_ret=0, bus_busy=0, csr_mtvec=32'h0000_1003:
  - that cycle stall=6'b111111;
  - next cycle flush=1, new_pc=32'h0000_1000, stall=0;
  - the following cycle flush=0.
- except_valid=1, except_is_ret=1, csr_mepc=32'h0000_2468, bus_busy=1 for 3 cycles:
  - stall=6'b111111 for 4 cycles (3 busy + 1 accept);
  - then flush=1 with new_pc=32'h0000_2468.
- Assert rst=0 during TRAP_WAIT → all outputs 0 at once. Release rst → state RUN, no flush pulse.
- With PIPE_CTRL_WDOG_EN and WDOG_LIMIT=8: hold stallreq_mem=1 → wdog_timeout rises after 8 request cycles and stays 1 after the request drops. A 7-cycle burst followed by a 1-cycle gap leaves it 0.
